// File: rtl/rate_limit_controller_pkg.sv
// Shared constants, FSM state encodings and saturating limit arithmetic for rate_limit_controller.
package rate_ctrl_pkg;

    localparam int RATE_DEFAULT_LIMIT = 1136;
    localparam int RATE_MIN_LIMIT     = 568;
    localparam int RATE_MAX_LIMIT     = 2272;
    localparam int RATE_STEP          = 16;
    localparam int RATE_REPEAT_DELAY  = 25000000;
    localparam int RATE_REPEAT_PERIOD = 5000000;

    typedef logic [1:0] rate_state_t;
    localparam rate_state_t ST_IDLE   = 2'd0;
    localparam rate_state_t ST_HOLD   = 2'd1;
    localparam rate_state_t ST_REPEAT = 2'd2;

    // Compare against min + step so the subtraction can never wrap below zero.
    function automatic logic [31:0] limit_dec(input logic [31:0] value,
                                              input logic [31:0] step,
                                              input logic [31:0] min_limit);
        logic [32:0] floor_sum;
        floor_sum = {1'b0, min_limit} + {1'b0, step};
        if ({1'b0, value} < floor_sum)
            return min_limit;
        else
            return value - step;
    endfunction

    function automatic logic [31:0] limit_inc(input logic [31:0] value,
                                              input logic [31:0] step,
                                              input logic [31:0] max_limit);
        logic [32:0] sum;
        sum = {1'b0, value} + {1'b0, step};
        if (sum > {1'b0, max_limit})
            return max_limit;
        else
            return sum[31:0];
    endfunction

endpackage

// File: rtl/rate_limit_controller_button_sync.sv
// Two-flop synchronizer plus rising-edge detector for one asynchronous button level.
module button_sync (
    input  logic clk_signal_in,
    input  logic reset,
    input  logic button,
    output logic level,
    output logic rise
);

    logic [1:0] sync_reg;
    logic       prev_reg;

    always_ff @(posedge clk_signal_in) begin
        if (reset) begin
            sync_reg <= 2'b00;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], button};
            prev_reg <= sync_reg[1];
        end
    end

    assign level = sync_reg[1];
    assign rise  = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/rate_limit_controller.sv
// Button-driven limit controller for a downstream clock divider.
// Optional auto-repeat of a held speed_up/speed_down is enabled by defining RATE_AUTO_REPEAT_EN.
module rate_limit_controller
    import rate_ctrl_pkg::*;
#(
    parameter int DEFAULT_LIMIT = RATE_DEFAULT_LIMIT,
    parameter int MIN_LIMIT     = RATE_MIN_LIMIT,
    parameter int MAX_LIMIT     = RATE_MAX_LIMIT,
    parameter int STEP          = RATE_STEP,
    parameter int REPEAT_DELAY  = RATE_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = RATE_REPEAT_PERIOD
) (
    input  logic        clk_signal_in,
    input  logic        reset,
    input  logic        speed_up,
    input  logic        speed_down,
    input  logic        speed_reset,
    output logic [31:0] counter_limit,
    output logic        limit_valid,
    output logic        at_min,
    output logic        at_max
);

    localparam logic [31:0] DEFAULT_L = 32'(DEFAULT_LIMIT);
    localparam logic [31:0] MIN_L     = 32'(MIN_LIMIT);
    localparam logic [31:0] MAX_L     = 32'(MAX_LIMIT);
    localparam logic [31:0] STEP_L    = 32'(STEP);

    // Bit 0 = speed_up, bit 1 = speed_down, bit 2 = speed_reset.
    logic [2:0] button_in;
    logic [2:0] level;
    logic [2:0] rise;

    assign button_in = {speed_reset, speed_down, speed_up};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            button_sync u_button_sync (
                .clk_signal_in (clk_signal_in),
                .reset         (reset),
                .button        (button_in[gi]),
                .level         (level[gi]),
                .rise          (rise[gi])
            );
        end
    endgenerate

    rate_state_t state_reg, state_next;
    logic [31:0] limit_reg, limit_next;
    logic        valid_reg, at_min_reg, at_max_reg;
    logic        apply_up, apply_down, apply_rst;

`ifdef RATE_AUTO_REPEAT_EN
    localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    logic [31:0] timer_reg, timer_next;
    logic        held_up_reg, held_up_next;
    logic        held_down_reg, held_down_next;
    logic        repeat_ok;

    // Only the direction that opened the hold may repeat, and only while pressed alone.
    assign repeat_ok = ~level[2] & ((held_up_reg & level[0] & ~level[1]) |
                                    (held_down_reg & level[1] & ~level[0]));
`endif

    always_comb begin
        state_next = state_reg;
        apply_up   = 1'b0;
        apply_down = 1'b0;
        apply_rst  = 1'b0;
`ifdef RATE_AUTO_REPEAT_EN
        timer_next     = timer_reg;
        held_up_next   = held_up_reg;
        held_down_next = held_down_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (|rise) begin
                    state_next = ST_HOLD;
                    apply_rst  = rise[2];
                    apply_up   = ~rise[2] & rise[0] & ~rise[1];
                    apply_down = ~rise[2] & rise[1] & ~rise[0];
`ifdef RATE_AUTO_REPEAT_EN
                    timer_next     = '0;
                    held_up_next   = ~rise[2] & rise[0] & ~rise[1];
                    held_down_next = ~rise[2] & rise[1] & ~rise[0];
`endif
                end
            end
            ST_HOLD: begin
                if (~|level) begin
                    state_next = ST_IDLE;
`ifdef RATE_AUTO_REPEAT_EN
                end else if (repeat_ok) begin
                    if (timer_reg == DELAY_LAST) begin
                        state_next = ST_REPEAT;
                        timer_next = '0;
                        apply_up   = held_up_reg;
                        apply_down = held_down_reg;
                    end else begin
                        timer_next = timer_reg + 32'd1;
                    end
                end else begin
                    timer_next = '0;
`endif
                end
            end
`ifdef RATE_AUTO_REPEAT_EN
            ST_REPEAT: begin
                if (~|level) begin
                    state_next = ST_IDLE;
                end else if (repeat_ok) begin
                    if (timer_reg == PERIOD_LAST) begin
                        timer_next = '0;
                        apply_up   = held_up_reg;
                        apply_down = held_down_reg;
                    end else begin
                        timer_next = timer_reg + 32'd1;
                    end
                end else begin
                    timer_next = '0;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        limit_next = limit_reg;
        if (apply_rst)
            limit_next = DEFAULT_L;
        else if (apply_up)
            limit_next = limit_dec(limit_reg, STEP_L, MIN_L);
        else if (apply_down)
            limit_next = limit_inc(limit_reg, STEP_L, MAX_L);
    end

    always_ff @(posedge clk_signal_in) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            limit_reg  <= DEFAULT_L;
            valid_reg  <= 1'b0;
            at_min_reg <= (DEFAULT_L == MIN_L);
            at_max_reg <= (DEFAULT_L == MAX_L);
        end else begin
            state_reg  <= state_next;
            limit_reg  <= limit_next;
            valid_reg  <= (limit_next != limit_reg);
            at_min_reg <= (limit_next == MIN_L);
            at_max_reg <= (limit_next == MAX_L);
        end
    end

`ifdef RATE_AUTO_REPEAT_EN
    always_ff @(posedge clk_signal_in) begin
        if (reset) begin
            timer_reg     <= '0;
            held_up_reg   <= 1'b0;
            held_down_reg <= 1'b0;
        end else begin
            timer_reg     <= timer_next;
            held_up_reg   <= held_up_next;
            held_down_reg <= held_down_next;
        end
    end
`endif

    assign counter_limit = limit_reg;
    assign limit_valid   = valid_reg;
    assign at_min        = at_min_reg;
    assign at_max        = at_max_reg;

endmodule

// File: tb/tb_rate_limit_controller.sv
// Directed self-checking bench for rate_limit_controller; auto-repeat expectations follow RATE_AUTO_REPEAT_EN.
module tb_rate_limit_controller;

    logic        clk_signal_in = 1'b0;
    logic        reset         = 1'b1;
    logic        speed_up      = 1'b0;
    logic        speed_down    = 1'b0;
    logic        speed_reset   = 1'b0;
    logic [31:0] counter_limit;
    logic        limit_valid;
    logic        at_min;
    logic        at_max;

    int checks      = 0;
    int errors      = 0;
    int pulse_count = 0;
    int base;

    rate_limit_controller #(
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk_signal_in (clk_signal_in),
        .reset         (reset),
        .speed_up      (speed_up),
        .speed_down    (speed_down),
        .speed_reset   (speed_reset),
        .counter_limit (counter_limit),
        .limit_valid   (limit_valid),
        .at_min        (at_min),
        .at_max        (at_max)
    );

    always #5 clk_signal_in = ~clk_signal_in;

    always @(negedge clk_signal_in) begin
        if (limit_valid)
            pulse_count++;
    end

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end else begin
            $display("check %s: %0d ok", tag, actual);
        end
    endtask

    // btns = {speed_reset, speed_down, speed_up}; driven on falling edges.
    task automatic press(input logic [2:0] btns, input int hold);
        {speed_reset, speed_down, speed_up} = btns;
        repeat (hold) @(negedge clk_signal_in);
        {speed_reset, speed_down, speed_up} = 3'b000;
        repeat (5) @(negedge clk_signal_in);
    endtask

    int exp_cyc[5] = '{3, 23, 28, 33, 38};
    logic [31:0] exp_val[5] = '{32'd1152, 32'd1168, 32'd1184, 32'd1200, 32'd1216};
    int exp_n;
    int idx;

    initial begin
`ifdef RATE_AUTO_REPEAT_EN
        exp_n = 5;
`else
        exp_n = 1;
`endif
        repeat (3) @(negedge clk_signal_in);
        reset = 1'b0;
        @(negedge clk_signal_in);
        check_value("reset_limit", counter_limit, 32'd1136);
        check_value("reset_at_min", 32'(at_min), 32'd0);
        check_value("reset_at_max", 32'(at_max), 32'd0);
        check_value("reset_valid", 32'(limit_valid), 32'd0);

        // Single speed_up held 10 cycles: update lands on the 3rd edge.
        base = pulse_count;
        speed_up = 1'b1;
        repeat (2) @(negedge clk_signal_in);
        check_value("up_edge2_limit", counter_limit, 32'd1136);
        @(negedge clk_signal_in);
        check_value("up_edge3_limit", counter_limit, 32'd1120);
        check_value("up_edge3_valid", 32'(limit_valid), 32'd1);
        @(negedge clk_signal_in);
        check_value("up_edge4_valid", 32'(limit_valid), 32'd0);
        repeat (6) @(negedge clk_signal_in);
        speed_up = 1'b0;
        repeat (5) @(negedge clk_signal_in);
        check_value("up_pulses", 32'(pulse_count - base), 32'd1);

        // 36 presses from 1120: the 35th reaches 568, the 36th changes nothing.
        base = pulse_count;
        for (int i = 0; i < 35; i++) press(3'b001, 4);
        check_value("sat_min_limit", counter_limit, 32'd568);
        check_value("sat_min_at_min", 32'(at_min), 32'd1);
        check_value("sat_min_pulses", 32'(pulse_count - base), 32'd35);
        base = pulse_count;
        press(3'b001, 4);
        check_value("sat_min_36th_limit", counter_limit, 32'd568);
        check_value("sat_min_36th_pulses", 32'(pulse_count - base), 32'd0);

        press(3'b100, 4);
        check_value("speed_reset_limit", counter_limit, 32'd1136);
        check_value("speed_reset_at_min", 32'(at_min), 32'd0);

        base = pulse_count;
        press(3'b011, 4);
        check_value("up_down_limit", counter_limit, 32'd1136);
        check_value("up_down_pulses", 32'(pulse_count - base), 32'd0);

        for (int i = 0; i < 4; i++) press(3'b010, 4);
        check_value("down4_limit", counter_limit, 32'd1200);
        base = pulse_count;
        press(3'b111, 4);
        check_value("all3_limit", counter_limit, 32'd1136);
        check_value("all3_pulses", 32'(pulse_count - base), 32'd1);

        // speed_down arriving while speed_up is still held is ignored.
        base = pulse_count;
        speed_up = 1'b1;
        repeat (5) @(negedge clk_signal_in);
        speed_down = 1'b1;
        repeat (5) @(negedge clk_signal_in);
        speed_up = 1'b0;
        speed_down = 1'b0;
        repeat (5) @(negedge clk_signal_in);
        check_value("hold_ignore_limit", counter_limit, 32'd1120);
        check_value("hold_ignore_pulses", 32'(pulse_count - base), 32'd1);

        press(3'b010, 4);
        check_value("down_from_1120", counter_limit, 32'd1136);
        for (int i = 0; i < 71; i++) press(3'b010, 4);
        check_value("sat_max_limit", counter_limit, 32'd2272);
        check_value("sat_max_at_max", 32'(at_max), 32'd1);
        base = pulse_count;
        press(3'b010, 4);
        check_value("sat_max_extra_limit", counter_limit, 32'd2272);
        check_value("sat_max_extra_pulses", 32'(pulse_count - base), 32'd0);
        press(3'b100, 4);
        check_value("back_to_default", counter_limit, 32'd1136);

        // speed_down held 40 cycles; record each limit_valid by cycle number.
        idx = 0;
        speed_down = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk_signal_in);
            if (limit_valid) begin
                if (idx < exp_n) begin
                    check_value($sformatf("repeat%0d_cycle", idx), 32'(k), 32'(exp_cyc[idx]));
                    check_value($sformatf("repeat%0d_value", idx), counter_limit, exp_val[idx]);
                end else begin
                    check_value("repeat_extra_pulse_cycle", 32'(k), 32'd0);
                end
                idx++;
            end
            if (k == 40)
                speed_down = 1'b0;
        end
        check_value("repeat_count", 32'(idx), 32'(exp_n));
        check_value("repeat_final", counter_limit, exp_val[exp_n-1]);

        // Reset lands right after speed_down is synchronized, abandoning the request.
        speed_down = 1'b1;
        repeat (2) @(negedge clk_signal_in);
        reset = 1'b1;
        speed_down = 1'b0;
        repeat (2) @(negedge clk_signal_in);
        reset = 1'b0;
        base = pulse_count;
        repeat (6) @(negedge clk_signal_in);
        check_value("midreset_limit", counter_limit, 32'd1136);
        check_value("midreset_pulses", 32'(pulse_count - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
